// File: rtl/freq_step_selector.sv
// freq_step_selector: steps a preset index up/down from debounced push buttons
// and drives the matching clock-divider value and frequency (Hz) from registers.
// Optional feature: define FREQ_STEP_AUTOREPEAT_EN to auto-repeat a held button
// after REPEAT_CYCLES cycles, then every REPEAT_CYCLES/4 cycles.
module freq_step_selector #(
  parameter int unsigned NUM_STEPS = 8,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned DIV_W = 6,
  parameter int unsigned FREQ_W = 10,
  parameter logic [NUM_STEPS*DIV_W-1:0] DIV_TABLE =
    {6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd12, 6'd19, 6'd32},
  parameter logic [NUM_STEPS*FREQ_W-1:0] FREQ_TABLE =
    {10'd200, 10'd175, 10'd150, 10'd125, 10'd100, 10'd75, 10'd50, 10'd30},
  parameter int unsigned START_IDX = 0,
  parameter bit WRAP = 1'b1,
  parameter int unsigned REPEAT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PushBottonUp,
  input  logic              PushBottonDown,
  output logic [DIV_W-1:0]  FreqDivValue,
  output logic [FREQ_W-1:0] Freq,
  output logic [IDX_W-1:0]  idx,
  output logic              at_min,
  output logic              at_max,
  output logic              changed
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);
  localparam logic [IDX_W-1:0] START    = IDX_W'(START_IDX);

  // Reject parameter sets the index logic cannot represent
  generate
    if (NUM_STEPS < 2 || NUM_STEPS > 16 || (1 << IDX_W) < NUM_STEPS ||
        START_IDX >= NUM_STEPS || REPEAT_CYCLES < 4) begin : g_bad_params
      $error("freq_step_selector: illegal parameter combination");
    end
  endgenerate

  logic              up_q;
  logic              dn_q;
  logic              up_ev;
  logic              dn_ev;
  logic              step_up;
  logic              step_dn;
  logic [IDX_W-1:0]  idx_next;
  logic [DIV_W-1:0]  div_next;
  logic [FREQ_W-1:0] freq_next;

  // Rising-edge detection against the previous button levels
  assign up_ev = PushBottonUp & ~up_q;
  assign dn_ev = PushBottonDown & ~dn_q;

`ifdef FREQ_STEP_AUTOREPEAT_EN
  localparam int unsigned CNT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [CNT_W-1:0] FIRST_LIMIT = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] FAST_LIMIT  = CNT_W'(REPEAT_CYCLES / 4);

  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_cnt_inc;
  logic             rep_fast;
  logic             hold_one;
  logic             rep_fire;

  // A single button held at the same level as last cycle keeps the counter running
  always_comb begin
    hold_one    = (PushBottonUp ^ PushBottonDown) &
                  (PushBottonUp == up_q) & (PushBottonDown == dn_q);
    rep_cnt_inc = rep_cnt + CNT_W'(1);
    rep_fire    = hold_one & (rep_cnt_inc == (rep_fast ? FAST_LIMIT : FIRST_LIMIT));
  end

  // Repeat counter: slow first interval, then quarter-length intervals
  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_cnt  <= '0;
      rep_fast <= 1'b0;
    end else if (!hold_one) begin
      rep_cnt  <= '0;
      rep_fast <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt  <= '0;
      rep_fast <= 1'b1;
    end else begin
      rep_cnt  <= rep_cnt_inc;
    end
  end

  // Repeat events merge with the edge events
  assign step_up = (up_ev | (rep_fire & PushBottonUp)) &
                   ~(dn_ev | (rep_fire & PushBottonDown));
  assign step_dn = (dn_ev | (rep_fire & PushBottonDown)) &
                   ~(up_ev | (rep_fire & PushBottonUp));
`else
  // One step per rising edge; simultaneous edges cancel
  assign step_up = up_ev & ~dn_ev;
  assign step_dn = dn_ev & ~up_ev;
`endif

  // Next index with wrap/saturate end policy and out-of-range recovery
  always_comb begin
    idx_next = idx;
    if (idx > LAST_IDX) begin
      idx_next = START;
    end else if (step_up) begin
      if (idx < LAST_IDX) idx_next = idx + IDX_W'(1);
      else if (WRAP)      idx_next = '0;
    end else if (step_dn) begin
      if (idx != '0) idx_next = idx - IDX_W'(1);
      else if (WRAP) idx_next = LAST_IDX;
    end
  end

  // Preset lookup for the next index
  always_comb begin
    div_next  = '0;
    freq_next = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (idx_next == IDX_W'(i)) begin
        div_next  = DIV_TABLE[i*DIV_W +: DIV_W];
        freq_next = FREQ_TABLE[i*FREQ_W +: FREQ_W];
      end
    end
  end

  // Registered index, presets, flags and change strobe
  always_ff @(posedge clk) begin
    if (!reset) begin
      up_q         <= 1'b1;
      dn_q         <= 1'b1;
      idx          <= START;
      FreqDivValue <= DIV_TABLE[START_IDX*DIV_W +: DIV_W];
      Freq         <= FREQ_TABLE[START_IDX*FREQ_W +: FREQ_W];
      at_min       <= (START == '0);
      at_max       <= (START == LAST_IDX);
      changed      <= 1'b0;
    end else begin
      up_q         <= PushBottonUp;
      dn_q         <= PushBottonDown;
      idx          <= idx_next;
      FreqDivValue <= div_next;
      Freq         <= freq_next;
      at_min       <= (idx_next == '0);
      at_max       <= (idx_next == LAST_IDX);
      changed      <= (idx_next != idx);
    end
  end

endmodule

// File: tb/tb_freq_step_selector.sv
// Self-checking bench for freq_step_selector: a wrapping and a saturating
// instance share the same stimulus and are compared against a preset-list model.
module tb_freq_step_selector;

  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, up, dn;

  logic [5:0] w_div,  s_div;
  logic [9:0] w_freq, s_freq;
  logic [2:0] w_idx,  s_idx;
  logic       w_min, w_max, w_chg;
  logic       s_min, s_max, s_chg;

  freq_step_selector #(.WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .PushBottonUp(up), .PushBottonDown(dn),
    .FreqDivValue(w_div), .Freq(w_freq), .idx(w_idx),
    .at_min(w_min), .at_max(w_max), .changed(w_chg)
  );

  freq_step_selector #(.WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .PushBottonUp(up), .PushBottonDown(dn),
    .FreqDivValue(s_div), .Freq(s_freq), .idx(s_idx),
    .at_min(s_min), .at_max(s_max), .changed(s_chg)
  );

  int tests = 0;
  int fails = 0;

  int div_tab  [N] = '{32, 19, 12, 9, 7, 6, 5, 4};
  int freq_tab [N] = '{30, 50, 75, 100, 125, 150, 175, 200};

  // Model state: [0] wrapping instance, [1] saturating instance
  int m_idx [2];
  bit m_chg [2];
  bit m_pu, m_pd;

  function automatic int model_next(int cur, bit u_ev, bit d_ev, bit wrap);
    if (u_ev && !d_ev) return wrap ? (cur + 1) % N : ((cur + 1 > N - 1) ? N - 1 : cur + 1);
    if (d_ev && !u_ev) return wrap ? (cur + N - 1) % N : ((cur == 0) ? 0 : cur - 1);
    return cur;
  endfunction

  task automatic model_clock(bit r, bit u, bit d);
    bit ue, de;
    int nxt;
    if (!r) begin
      for (int k = 0; k < 2; k++) begin
        m_idx[k] = 0;
        m_chg[k] = 1'b0;
      end
      m_pu = 1'b1;
      m_pd = 1'b1;
    end else begin
      ue = u && !m_pu;
      de = d && !m_pd;
      for (int k = 0; k < 2; k++) begin
        nxt      = model_next(m_idx[k], ue, de, (k == 0));
        m_chg[k] = (nxt != m_idx[k]);
        m_idx[k] = nxt;
      end
      m_pu = u;
      m_pd = d;
    end
  endtask

  task automatic check_one(string name, int k, int a_idx, int a_div, int a_freq,
                           bit a_min, bit a_max, bit a_chg);
    int e_idx, e_div, e_freq;
    bit e_min, e_max;
    e_idx  = m_idx[k];
    e_div  = div_tab[e_idx];
    e_freq = freq_tab[e_idx];
    e_min  = (e_idx == 0);
    e_max  = (e_idx == N - 1);
    tests++;
    if (a_idx != e_idx || a_div != e_div || a_freq != e_freq ||
        a_min != e_min || a_max != e_max || a_chg != m_chg[k]) begin
      fails++;
      $display("FAIL %s[%s] t=%0t got idx=%0d div=%0d freq=%0d min=%0b max=%0b chg=%0b, expected idx=%0d div=%0d freq=%0d min=%0b max=%0b chg=%0b",
               name, (k == 0) ? "wrap" : "sat", $time, a_idx, a_div, a_freq, a_min, a_max, a_chg,
               e_idx, e_div, e_freq, e_min, e_max, m_chg[k]);
    end
  endtask

  task automatic expect_int(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs for one clock, sample just after the edge and compare both instances
  task automatic tick(string name, bit r, bit u, bit d);
    reset = r;
    up    = u;
    dn    = d;
    @(posedge clk);
    #1;
    model_clock(r, u, d);
    check_one(name, 0, int'(w_idx), int'(w_div), int'(w_freq), w_min, w_max, w_chg);
    check_one(name, 1, int'(s_idx), int'(s_div), int'(s_freq), s_min, s_max, s_chg);
  endtask

  task automatic do_reset();
    tick("reset", 1'b0, 1'b0, 1'b0);
    tick("reset", 1'b0, 1'b0, 1'b0);
    tick("release", 1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit up;
    bit dn;
    int idx_w;
    int idx_s;
    bit chg_w;
    bit chg_s;
  } vec_t;

  vec_t vecs [11];

  initial begin
    reset = 1'b0;
    up    = 1'b0;
    dn    = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 1, 1, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1, 1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1, 1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 7, 0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 7, 0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 7, 0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 7, 0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 0, 1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 0, 1, 1'b0, 1'b0};

    // Reset state against fixed constants
    do_reset();
    expect_int("rst_idx",  int'(w_idx),  0);
    expect_int("rst_div",  int'(w_div),  32);
    expect_int("rst_freq", int'(w_freq), 30);
    expect_int("rst_min",  int'(w_min),  1);
    expect_int("rst_chg",  int'(w_chg),  0);

    // Table-driven vectors through edges, holds, wrap and simultaneous presses
    for (int i = 0; i < 11; i++) begin
      tick("vec", 1'b1, vecs[i].up, vecs[i].dn);
      expect_int($sformatf("vec%0d_idx_w", i), int'(w_idx), vecs[i].idx_w);
      expect_int($sformatf("vec%0d_idx_s", i), int'(s_idx), vecs[i].idx_s);
      expect_int($sformatf("vec%0d_chg_w", i), int'(w_chg), int'(vecs[i].chg_w));
      expect_int($sformatf("vec%0d_chg_s", i), int'(s_chg), int'(vecs[i].chg_s));
    end
    expect_int("dn_wrap_freq", int'(w_freq), 30);

    // Up held for 50 cycles gives exactly one step
    do_reset();
    tick("hold50", 1'b1, 1'b1, 1'b0);
    expect_int("hold50_first_chg", int'(w_chg), 1);
    for (int i = 1; i < 50; i++) tick("hold50", 1'b1, 1'b1, 1'b0);
    expect_int("hold50_idx",  int'(w_idx),  1);
    expect_int("hold50_div",  int'(w_div),  19);
    expect_int("hold50_freq", int'(w_freq), 50);
    expect_int("hold50_chg",  int'(w_chg),  0);

    // Seven up pulses to the top, then one more: wrap vs saturate
    tick("pulse", 1'b1, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick("pulse", 1'b1, 1'b1, 1'b0);
      tick("pulse", 1'b1, 1'b0, 1'b0);
    end
    expect_int("top_idx_w",  int'(w_idx),  7);
    expect_int("top_div_w",  int'(w_div),  4);
    expect_int("top_freq_w", int'(w_freq), 200);
    expect_int("top_max_w",  int'(w_max),  1);
    expect_int("top_max_s",  int'(s_max),  1);
    tick("pulse", 1'b1, 1'b1, 1'b0);
    expect_int("wrap_idx",  int'(w_idx),  0);
    expect_int("wrap_div",  int'(w_div),  32);
    expect_int("wrap_freq", int'(w_freq), 30);
    expect_int("sat_idx",   int'(s_idx),  7);
    expect_int("sat_chg",   int'(s_chg),  0);

    // Up held through reset does not step until pressed again
    tick("step_up", 1'b1, 1'b0, 1'b0);
    tick("step_up", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick("rst_hold", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick("rst_hold", 1'b1, 1'b1, 1'b0);
    expect_int("rst_hold_idx", int'(w_idx), 0);
    tick("rst_hold", 1'b1, 1'b0, 1'b0);
    tick("rst_hold", 1'b1, 1'b1, 1'b0);
    expect_int("rst_hold_repress", int'(w_idx), 1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      tick("rand", ($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
